// File: rtl/carrier_loop_param_pkg.sv
// Shared types and default widths for the carrier tracking loop and its lock detector.
package carrier_loop_param_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } lock_state_t;

  localparam int DEF_ERR_W = 8;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/carrier_lock_fsm.sv
// Lock detector: hysteresis counter on |error| against a threshold, driving ACQUIRE/TRACK.
module carrier_lock_fsm
  import carrier_loop_param_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_err_en,
  input  logic [ERR_W-1:0] i_error,
  input  logic [ERR_W-1:0] i_sync_threshold,
  input  logic [CNT_W-1:0] i_lock_count,
  output logic [CNT_W-1:0] o_counter,
  output lock_state_t      o_state,
  output logic             o_locked
);

  localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  lock_state_t      r_state;
  lock_state_t      w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_step;
  logic [ERR_W-1:0] w_abs;
  logic             w_in_thr;

  // |most-negative| has no positive twin, so it folds onto the largest magnitude.
  assign w_abs    = !i_error[ERR_W-1] ? i_error :
                    (i_error == ERR_MIN) ? ERR_MAX : -i_error;
  assign w_in_thr = (w_abs <= i_sync_threshold);
  assign w_base   = (r_count > i_lock_count) ? i_lock_count : r_count;

  always_comb begin
    w_step = w_base;
    if (w_in_thr) begin
      if (w_base != i_lock_count) w_step = w_base + CNT_W'(1);
    end else begin
      if (w_base != '0) w_step = w_base - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACQUIRE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    if (i_err_en) begin
      if (i_lock_count == '0) begin
        w_state_next = ACQUIRE;
        w_count_next = '0;
      end else begin
        w_count_next = w_step;
        if (r_state == ACQUIRE && w_step == i_lock_count) w_state_next = TRACK;
        else if (r_state == TRACK && w_step == '0)       w_state_next = ACQUIRE;
      end
    end
  end

  always_comb begin
    o_state   = r_state;
    o_counter = r_count;
    o_locked  = (r_state == TRACK);
  end

endmodule

// File: rtl/carrier_loop_param.sv
// Carrier loop filter: conditioned error -> lead/lag gains -> saturating lag accumulator -> frequency word.
module carrier_loop_param
  import carrier_loop_param_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             errEn,
  input  logic [ERR_W-1:0] error,
  input  logic             invertError,
  input  logic             zeroError,
  input  logic             clearAccum,
  input  logic             sweepEnable,
  input  logic [4:0]       leadExpAcq,
  input  logic [4:0]       lagExpAcq,
  input  logic [4:0]       leadExpTrk,
  input  logic [4:0]       lagExpTrk,
  input  logic [ACC_W-1:0] limit,
  input  logic [ACC_W-1:0] sweepRate,
  input  logic [CNT_W-1:0] lockCount,
  input  logic [ERR_W-1:0] syncThreshold,
  output logic [OUT_W-1:0] freqOut,
  output logic             freqEn,
  output logic [ACC_W-1:0] lagAccum,
  output logic [CNT_W-1:0] lockCounter,
  output logic             locked,
  output logic             state
);

  localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  // errEn is a one-cycle valid strobe with no ready: every strobe is accepted and
  // yields exactly one freqEn three cycles later; the pipeline never stalls.
  logic                    r_en1, r_en2, r_en3;
  logic        [ERR_W-1:0] r_cond_err;
  logic        [ERR_W-1:0] w_cond_next;
  logic signed [ACC_W-1:0] r_lead_err, r_lag, r_sum;
  logic                    r_dir_neg;
  lock_state_t             w_state;

  logic signed [ACC_W-1:0] w_cond_ext, w_lead_next, w_lag_inc, w_sweep, w_lag_sat;
  logic signed [ACC_W+1:0] w_lag_sum, w_lim_pos, w_lim_neg;
  logic        [4:0]       w_lead_exp, w_lag_exp;
  logic                    w_sweep_on;

  always_comb begin
    w_cond_next = error;
    if (zeroError)        w_cond_next = '0;
    else if (invertError) w_cond_next = (error == ERR_MIN) ? ERR_MAX : -error;
  end

  assign w_cond_ext  = {{(ACC_W-ERR_W){r_cond_err[ERR_W-1]}}, r_cond_err};
  assign w_lead_exp  = (w_state == TRACK) ? leadExpTrk : leadExpAcq;
  assign w_lag_exp   = (w_state == TRACK) ? lagExpTrk  : lagExpAcq;
  assign w_lead_next = w_cond_ext << w_lead_exp;
  assign w_lag_inc   = w_cond_ext << w_lag_exp;
  assign w_sweep_on  = sweepEnable && (w_state == ACQUIRE);
  assign w_sweep     = !w_sweep_on ? '0 : (r_dir_neg ? -sweepRate : sweepRate);

  // Two guard bits keep lag + increment + sweep exact before clamping.
  assign w_lag_sum = {{2{r_lag[ACC_W-1]}}, r_lag}
                   + {{2{w_lag_inc[ACC_W-1]}}, w_lag_inc}
                   + {{2{w_sweep[ACC_W-1]}}, w_sweep};
  assign w_lim_pos = {2'b00, limit};
  assign w_lim_neg = -w_lim_pos;

  always_comb begin
    w_lag_sat = w_lag_sum[ACC_W-1:0];
    if (w_lag_sum > w_lim_pos)      w_lag_sat = w_lim_pos[ACC_W-1:0];
    else if (w_lag_sum < w_lim_neg) w_lag_sat = w_lim_neg[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en1      <= 1'b0;
      r_en2      <= 1'b0;
      r_en3      <= 1'b0;
      r_cond_err <= '0;
      r_lead_err <= '0;
      r_lag      <= '0;
      r_sum      <= '0;
      r_dir_neg  <= 1'b0;
    end else begin
      r_en1 <= errEn;
      r_en2 <= r_en1;
      r_en3 <= r_en2;
      if (errEn) r_cond_err <= w_cond_next;
      if (r_en1) r_lead_err <= w_lead_next;
      if (clearAccum)  r_lag <= '0;
      else if (r_en1)  r_lag <= w_lag_sat;
      // Sweep reverses on the update that runs into either rail.
      if (r_en1 && !clearAccum && w_sweep_on) begin
        if (w_lag_sum >= w_lim_pos)      r_dir_neg <= 1'b1;
        else if (w_lag_sum <= w_lim_neg) r_dir_neg <= 1'b0;
      end
      if (r_en2) r_sum <= r_lag + r_lead_err;
    end
  end

  carrier_lock_fsm #(
    .ERR_W(ERR_W),
    .CNT_W(CNT_W)
  ) u_lock (
    .clk              (clk),
    .reset            (reset),
    .i_err_en         (errEn),
    .i_error          (error),
    .i_sync_threshold (syncThreshold),
    .i_lock_count     (lockCount),
    .o_counter        (lockCounter),
    .o_state          (w_state),
    .o_locked         (locked)
  );

  assign state    = w_state;
  assign freqOut  = r_sum[ACC_W-1 -: OUT_W];
  assign freqEn   = r_en3;
  assign lagAccum = r_lag;

endmodule

// File: tb/tb_carrier_loop_param.sv
// Directed bench for carrier_loop_param with an expected-frequency queue checked on every freqEn.
module tb_carrier_loop_param;

  localparam int ERR_W = 8;
  localparam int ACC_W = 40;
  localparam int OUT_W = 32;
  localparam int CNT_W = 16;
  localparam logic [OUT_W-1:0] NEG1 = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic             errEn;
  logic [ERR_W-1:0] error;
  logic             invertError, zeroError, clearAccum, sweepEnable;
  logic [4:0]       leadExpAcq, lagExpAcq, leadExpTrk, lagExpTrk;
  logic [ACC_W-1:0] limit, sweepRate;
  logic [CNT_W-1:0] lockCount;
  logic [ERR_W-1:0] syncThreshold;
  logic [OUT_W-1:0] freqOut;
  logic             freqEn;
  logic [ACC_W-1:0] lagAccum;
  logic [CNT_W-1:0] lockCounter;
  logic             locked;
  logic             state;

  logic [OUT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  carrier_loop_param #(
    .ERR_W(ERR_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .errEn(errEn), .error(error),
    .invertError(invertError), .zeroError(zeroError),
    .clearAccum(clearAccum), .sweepEnable(sweepEnable),
    .leadExpAcq(leadExpAcq), .lagExpAcq(lagExpAcq),
    .leadExpTrk(leadExpTrk), .lagExpTrk(lagExpTrk),
    .limit(limit), .sweepRate(sweepRate),
    .lockCount(lockCount), .syncThreshold(syncThreshold),
    .freqOut(freqOut), .freqEn(freqEn), .lagAccum(lagAccum),
    .lockCounter(lockCounter), .locked(locked), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && freqEn) begin
      if (exp_q.size() == 0) check_eq("spurious_freqEn", freqEn, 0);
      else                   check_eq("freq_out", freqOut, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    tick(4);
    reset = 1'b1;
    exp_q.delete();
    tick(2);
    reset = 1'b0;
  endtask

  // Returns one negedge after the strobe cycle.
  task automatic send_err(input logic [ERR_W-1:0] e, input logic [OUT_W-1:0] f);
    @(negedge clk);
    errEn = 1'b1;
    error = e;
    exp_q.push_back(f);
    @(negedge clk);
    errEn = 1'b0;
  endtask

  int sweep_exp[12] = '{30, 60, 90, 100, 70, 40, 10, -20, -50, -80, -100, -70};

  initial begin
    reset = 1'b1; errEn = 1'b0; error = '0;
    invertError = 1'b0; zeroError = 1'b0; clearAccum = 1'b0; sweepEnable = 1'b0;
    leadExpAcq = 5'd4; lagExpAcq = 5'd0; leadExpTrk = 5'd2; lagExpTrk = 5'd0;
    limit = 40'd1 << 38; sweepRate = 40'd30;
    lockCount = '0; syncThreshold = 8'd10;
    tick(3);
    reset = 1'b0;

    // reset state
    check_eq("rst_freqOut", freqOut, 0);
    check_eq("rst_freqEn", freqEn, 0);
    check_eq("rst_lag", $signed(lagAccum), 0);
    check_eq("rst_cnt", lockCounter, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_state", state, 0);

    // single errEn: lead 16 + lag 1 = 17 lies below the freqOut LSB
    send_err(8'sd1, 0);
    check_eq("lat_n1_fe", freqEn, 0);
    tick(1);
    check_eq("lat_lag", $signed(lagAccum), 1);
    check_eq("lat_n2_fe", freqEn, 0);
    tick(1);
    check_eq("lat_n3_fe", freqEn, 1);
    check_eq("lat_n3_fo", freqOut, 0);
    tick(1);
    check_eq("lat_n4_fe", freqEn, 0);

    // larger lead gain: lag 2 + 1024 = 1026 -> 4
    leadExpAcq = 5'd10;
    send_err(8'sd1, 32'd4);
    tick(2);
    check_eq("gain_fo", freqOut, 4);
    leadExpAcq = 5'd4;

    // back-to-back strobes, lag 2 -> 3 -> 5
    @(negedge clk); errEn = 1'b1; error = 8'sd1; exp_q.push_back(0);
    @(negedge clk); error = 8'sd2; exp_q.push_back(0);
    @(negedge clk); errEn = 1'b0;
    tick(1);
    check_eq("b2b_fe1", freqEn, 1);
    check_eq("b2b_lag", $signed(lagAccum), 5);
    tick(1);
    check_eq("b2b_fe2", freqEn, 1);
    tick(1);
    check_eq("b2b_fe3", freqEn, 0);

    // negative sum: lag 4 - 16 = -12 -> all-ones word
    send_err(-8'sd1, NEG1);
    tick(1);
    check_eq("neg_lag", $signed(lagAccum), 4);

    // lag saturation and error conditioning
    do_reset();
    limit = 40'd100; leadExpAcq = 5'd0;
    send_err(8'sd127, 0); tick(1);
    check_eq("sat_lag1", $signed(lagAccum), 100);
    send_err(8'sd127, 0); tick(1);
    check_eq("sat_lag2", $signed(lagAccum), 100);
    invertError = 1'b1; leadExpAcq = 5'd20;
    send_err(8'h80, 32'd520192); tick(2);
    check_eq("inv_min_fo", freqOut, 520192);
    invertError = 1'b0; leadExpAcq = 5'd0;
    send_err(8'h80, NEG1); tick(1);
    check_eq("sat_lag3", $signed(lagAccum), -28);
    send_err(8'h80, NEG1); tick(1);
    check_eq("sat_lag4", $signed(lagAccum), -100);
    zeroError = 1'b1;
    send_err(8'sd50, NEG1); tick(1);
    check_eq("zero_lag", $signed(lagAccum), -100);
    zeroError = 1'b0;

    // lock detector hysteresis
    do_reset();
    limit = 40'd1 << 38; leadExpAcq = 5'd4;
    lockCount = 16'd3; syncThreshold = 8'd10;
    send_err(8'sd5, 0); check_eq("lk_c1", lockCounter, 1); check_eq("lk_l1", locked, 0);
    send_err(8'sd5, 0); check_eq("lk_c2", lockCounter, 2); check_eq("lk_l2", locked, 0);
    send_err(8'sd5, 0); check_eq("lk_c3", lockCounter, 3); check_eq("lk_l3", locked, 1);
    send_err(8'sd5, 0); check_eq("lk_csat", lockCounter, 3); check_eq("lk_st", state, 1);
    send_err(8'sd20, 0); check_eq("lk_c4", lockCounter, 2); check_eq("lk_l4", locked, 1);
    send_err(8'sd20, 0); check_eq("lk_c5", lockCounter, 1); check_eq("lk_l5", locked, 1);
    send_err(8'sd20, 32'd1); check_eq("lk_c6", lockCounter, 0); check_eq("lk_l6", locked, 0);
    send_err(8'sd5, 0);
    send_err(8'sd5, 0);
    send_err(8'sd5, 0); check_eq("lk_relock", locked, 1);
    lockCount = 16'd1;
    send_err(8'sd5, 0); check_eq("clamp_c", lockCounter, 1); check_eq("clamp_l", locked, 1);
    send_err(8'sd20, 32'd1); check_eq("clamp_drop", locked, 0);
    lockCount = 16'd0;
    send_err(8'sd5, 0); check_eq("lc0_c", lockCounter, 0); check_eq("lc0_l", locked, 0);
    lockCount = 16'd3; syncThreshold = 8'd127;
    send_err(8'h80, 32'hFFFF_FFF7); check_eq("abs_min_in", lockCounter, 1);
    syncThreshold = 8'd126;
    send_err(8'h80, 32'hFFFF_FFF7); check_eq("abs_min_out", lockCounter, 0);
    syncThreshold = 8'd10;
    send_err(8'sd10, 0); check_eq("thr_equal", lockCounter, 1);

    // sweep bouncing between the rails
    do_reset();
    lockCount = 16'd0; sweepEnable = 1'b1; limit = 40'd100;
    for (int i = 0; i < 12; i++) begin
      send_err(8'sd0, (sweep_exp[i] < 0) ? NEG1 : 32'd0);
      tick(1);
      check_eq($sformatf("sweep_%0d", i), $signed(lagAccum), sweep_exp[i]);
    end

    // locking freezes the sweep
    do_reset();
    lockCount = 16'd2;
    send_err(8'sd0, 0); tick(1);
    check_eq("swlk_lag1", $signed(lagAccum), 30);
    send_err(8'sd0, 0);
    check_eq("swlk_locked", locked, 1);
    tick(1);
    check_eq("swlk_lag2", $signed(lagAccum), 30);
    send_err(8'sd0, 0); tick(1);
    check_eq("swlk_lag3", $signed(lagAccum), 30);

    // clearAccum priority and reset mid-pipeline
    do_reset();
    sweepEnable = 1'b0; lockCount = 16'd0; limit = 40'd1 << 38;
    send_err(8'sd5, 0); tick(1);
    check_eq("clr_pre", $signed(lagAccum), 5);
    clearAccum = 1'b1;
    send_err(8'sd7, 0); tick(1);
    check_eq("clr_lag", $signed(lagAccum), 0);
    clearAccum = 1'b0;
    send_err(8'sd3, 0); tick(1);
    check_eq("clr_post", $signed(lagAccum), 3);
    tick(3);
    send_err(8'sd9, 0);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    tick(1);
    check_eq("rstmid_n3_fe", freqEn, 0);
    check_eq("rstmid_lag", $signed(lagAccum), 0);
    tick(1);
    check_eq("rstmid_n4_fe", freqEn, 0);
    send_err(8'sd1, 0); tick(1);
    check_eq("post_rst_lag", $signed(lagAccum), 1);
    tick(1);
    check_eq("post_rst_fe", freqEn, 1);

    tick(4);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
